fir_sequencer: RTL
==================

// Module: fir_sequencer
// PURPOSE
//  Per-sample sequencer directly upstream of the adaptive FIR (fir). It captures reference and
//  error microphone samples and forms the LMS step weight_adjust = sat16(mu*e >>> 15). It drives
//  one fir_go handshake per sample, waits for fir_done and republishes the FIR result as the
//  anti-noise sample. It also guards against sample overruns and a hung FIR.
// PARAMETERS
//  TIMEOUT_CYC   512  max cycles waited for fir_done after fir_go; must exceed FIR latency (TAPS+8)
//  NEG_ERR       1    1: step uses -err (sat16), 0: uses +err
//  CNT_W         8    width of overrun counter (saturating)
// PORTS
//  clk                 in   1      system clock
//  rst_n               in   1      asynchronous active-low reset
//  sample_valid        in   1      1-cycle strobe: ref_in/err_in valid
//  ref_in              in   16     reference mic sample, signed Q1.15
//  err_in              in   16     error mic sample, signed Q1.15
//  mu_in               in   16     step size, signed Q1.15 (quasi-static)
//  adapt_en            in   1      0: weight_adjust forced 0 (weights frozen)
//  bias_in             in   16     accumulator seed passed as fir_a_in
//  fir_x_in            out  16     to fir x_in
//  fir_a_in            out  16     to fir a_in
//  fir_weight_adjust   out  16     to fir weight_adjust
//  fir_go              out  1      to fir fir_go, 1-cycle pulse
//  fir_out_sample      in   16     from fir out_sample
//  fir_done            in   1      from fir done (coincident with out_valid)
//  anti_out            out  16     anti-noise sample to DAC path, held between updates
//  anti_valid          out  1      1-cycle strobe, anti_out updated
//  busy                out  1      high in any state other than IDLE
//  overrun_cnt         out  CNT_W  samples dropped while busy, saturates at all-ones
//  timeout_err         out  1      sticky; set on FIR timeout; cleared only by reset
// BEHAVIOUR
//  Reset (async, rst_n=0): all outputs 0, state IDLE, counters 0; any in-flight sample is discarded.
//  FSM: IDLE -> CALC -> LAUNCH -> WAIT -> OUTPUT -> IDLE.
//   IDLE:   on sample_valid, register ref_in, err_in and bias_in; register eff_err
//           (NEG_ERR ? sat16(-err_in) : err_in; -32768 maps to 32767); go to CALC.
//   CALC:   prod = mu_in*eff_err (32b signed); step = sat16(prod >>> 15) (17b result clamped to
//           [-32768,32767]); register step, or 0 when adapt_en=0; go to LAUNCH.
//   LAUNCH: fir_go=1 for exactly this cycle; fir_x_in/fir_a_in/fir_weight_adjust are registered
//           and stay stable from CALC exit until the next IDLE capture. Go to WAIT and clear timer.
//   WAIT:   timer counts up each cycle. fir_done -> latch fir_out_sample, go to OUTPUT.
//           If timer reaches TIMEOUT_CYC-1 without fir_done: set timeout_err, anti_out unchanged,
//           go to IDLE. A late fir_done arriving in IDLE is ignored.
//   OUTPUT: anti_out <= latched sample, anti_valid=1 for one cycle; go to IDLE.
//  Latency: sample_valid to fir_go = 2 cycles; fir_done to anti_valid = 2 cycles.
//  Overrun: sample_valid in any state other than IDLE (including the cycle fir_done arrives) is
//   dropped and increments overrun_cnt (saturating); the in-flight sample is unaffected.
//  fir_done outside WAIT is ignored. Only one sample is in flight at a time.
//  mu_in, adapt_en and bias_in are sampled in CALC/IDLE; changes mid-flight affect the next sample.
// STRUCTURE
//  Shared package anc_pkg: Q15 width localparam (16), Q15_MAX/Q15_MIN constants, FSM state
//   enum (IDLE/CALC/LAUNCH/WAIT/OUTPUT, 3-bit encoding).
//  The existing saturate module is reused for both sat16 instances (17->16 on the step, 17->16 on
//   negation). The existing bw_mult module is reused for mu*err.
//  One natural sub-module: seq_watchdog (timer + timeout flag). All other logic is flat.
// TESTING
//  1 mu=0x4000, err=0x2000, NEG_ERR=0, adapt_en=1 -> fir_weight_adjust=0x1000; fir_go pulse
//    2 cycles after sample_valid, 1 cycle wide.
//  2 mu=0x7FFF, err=0x8000, NEG_ERR=1 -> eff_err=0x7FFF, step=0x7FFE;
//    mu=0x8000, err=0x8000, NEG_ERR=0 -> step saturates to 0x7FFF.
//  3 FIR model returns 0x1234 with done 263 cycles after go -> anti_out=0x1234, anti_valid
//    2 cycles later; busy low afterwards.
//  4 Three sample_valid strobes while in WAIT -> overrun_cnt=3; FIR receives only the first
//    sample; a new sample accepted after return to IDLE is processed normally.
//  5 FIR model never asserts done -> timeout_err=1 exactly TIMEOUT_CYC cycles after go;
//    anti_valid never pulses; the next sample is processed normally.
//  6 rst_n pulled low mid-WAIT -> all outputs 0 immediately; a stale fir_done after release
//    is ignored; adapt_en=0 -> fir_weight_adjust=0.

Source files
------------

// File: rtl/anc_pkg.sv
// Shared types and constants for the ANC sample path.
// Q15 sample format and the per-sample sequencer state encoding.
package anc_pkg;

    localparam int Q15_W = 16;
    localparam logic signed [Q15_W-1:0] Q15_MAX = 16'sh7FFF;
    localparam logic signed [Q15_W-1:0] Q15_MIN = 16'sh8000;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CALC   = 3'd1,
        LAUNCH = 3'd2,
        WAIT   = 3'd3,
        OUTPUT = 3'd4
    } seq_state_t;

endpackage

// File: rtl/bw_mult.sv
// Full-precision signed multiplier.
module bw_mult #(
    parameter int A_W = 16,
    parameter int B_W = 16
) (
    input  logic signed [A_W-1:0]     a,
    input  logic signed [B_W-1:0]     b,
    output logic signed [A_W+B_W-1:0] p
);

    assign p = a * b;

endmodule

// File: rtl/saturate.sv
// Signed saturating narrowing: clamps an IN_W-bit value into OUT_W bits.
module saturate #(
    parameter int IN_W  = 17,
    parameter int OUT_W = 16
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout
);

    logic [IN_W-OUT_W:0] top;
    logic                fits;

    // Value fits when every dropped bit equals the new sign bit.
    assign top  = din[IN_W-1:OUT_W-1];
    assign fits = (&top) | ~(|top);

    always_comb begin
        dout = din[OUT_W-1:0];
        if (!fits) begin
            dout = din[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/seq_watchdog.sv
// Cycle timer started with fir_go; flags a hung FIR with a sticky error.
module seq_watchdog #(
    parameter int TIMEOUT_CYC = 512
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic run,
    input  logic check,
    input  logic done,
    output logic expired,
    output logic timeout_err
);

    localparam int TW = $clog2(TIMEOUT_CYC);

    logic [TW-1:0] timer;

    // Timer holds the number of cycles since fir_go was raised.
    assign expired = check && !done && (timer == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer       <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (clear) begin
                timer <= '0;
            end else if (run && timer != '1) begin
                timer <= timer + 1'b1;
            end
            if (expired) begin
                timeout_err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/fir_sequencer.sv
// Per-sample sequencer in front of the adaptive FIR: forms the LMS step,
// handshakes one FIR pass per sample and republishes its result as anti-noise.
module fir_sequencer
    import anc_pkg::*;
#(
    parameter int TIMEOUT_CYC = 512,
    parameter bit NEG_ERR     = 1'b1,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sample_valid,
    input  logic [15:0]      ref_in,
    input  logic [15:0]      err_in,
    input  logic [15:0]      mu_in,
    input  logic             adapt_en,
    input  logic [15:0]      bias_in,
    output logic [15:0]      fir_x_in,
    output logic [15:0]      fir_a_in,
    output logic [15:0]      fir_weight_adjust,
    output logic             fir_go,
    input  logic [15:0]      fir_out_sample,
    input  logic             fir_done,
    output logic [15:0]      anti_out,
    output logic             anti_valid,
    output logic             busy,
    output logic [CNT_W-1:0] overrun_cnt,
    output logic             timeout_err
);

    seq_state_t state, next_state;

    logic signed [Q15_W-1:0]   ref_q, bias_q, err_eff_q, sample_q;
    logic signed [Q15_W:0]     err_neg, step_wide;
    logic signed [Q15_W-1:0]   err_neg_sat, err_eff, step_sat;
    logic signed [2*Q15_W-1:0] prod;
    logic                      expired;

    // -(-32768) does not fit in Q15, so negation goes through a 17-bit saturator.
    assign err_neg = -$signed({err_in[Q15_W-1], err_in});

    saturate #(.IN_W(Q15_W + 1), .OUT_W(Q15_W)) u_sat_neg (
        .din  (err_neg),
        .dout (err_neg_sat)
    );

    assign err_eff = NEG_ERR ? err_neg_sat : $signed(err_in);

    bw_mult #(.A_W(Q15_W), .B_W(Q15_W)) u_mult (
        .a (mu_in),
        .b (err_eff_q),
        .p (prod)
    );

    assign step_wide = (Q15_W + 1)'(prod >>> 15);

    saturate #(.IN_W(Q15_W + 1), .OUT_W(Q15_W)) u_sat_step (
        .din  (step_wide),
        .dout (step_sat)
    );

    seq_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_watchdog (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (state == CALC),
        .run         (state == LAUNCH || state == WAIT),
        .check       (state == WAIT),
        .done        (fir_done),
        .expired     (expired),
        .timeout_err (timeout_err)
    );

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (sample_valid) next_state = CALC;
            CALC:    next_state = LAUNCH;
            LAUNCH:  next_state = WAIT;
            WAIT: begin
                if (fir_done) begin
                    next_state = OUTPUT;
                end else if (expired) begin
                    next_state = IDLE;
                end
            end
            OUTPUT:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            fir_x_in          <= '0;
            fir_a_in          <= '0;
            fir_weight_adjust <= '0;
            fir_go            <= 1'b0;
            anti_out          <= '0;
            anti_valid        <= 1'b0;
            overrun_cnt       <= '0;
        end else begin
            state      <= next_state;
            fir_go     <= (state == CALC);
            anti_valid <= (state == OUTPUT);
            // FIR operands are launched from CALC so they are steady during fir_go and WAIT.
            if (state == CALC) begin
                fir_x_in          <= ref_q;
                fir_a_in          <= bias_q;
                fir_weight_adjust <= adapt_en ? step_sat : '0;
            end
            if (state == OUTPUT) begin
                anti_out <= sample_q;
            end
            if (sample_valid && state != IDLE && overrun_cnt != '1) begin
                overrun_cnt <= overrun_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && sample_valid) begin
            ref_q     <= ref_in;
            bias_q    <= bias_in;
            err_eff_q <= err_eff;
        end
        if (state == WAIT && fir_done) begin
            sample_q <= fir_out_sample;
        end
    end

endmodule
